// File: rtl/row_delay_line_5x5_pkg.sv
// Shared constants for the 5x5 separable Gaussian line buffer.
//   - default pixel width and default image geometry
//   - the 1-D kernel [1 4 6 4 1] and its >>4 normalisation
//   - gauss5_norm(): one 1-D pass over a 5-pixel column or row
package row_delay_line_5x5_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 8;
   localparam int unsigned IMG_WIDTH      = 9;
   localparam int unsigned IMG_HEIGHT     = 6;

   localparam int unsigned KERNEL_TAPS  = 5;
   localparam int unsigned KERNEL_SHIFT = 4;
   localparam int unsigned KERNEL_K0    = 1;
   localparam int unsigned KERNEL_K1    = 4;
   localparam int unsigned KERNEL_K2    = 6;

   // Kernel weights sum to 16, so the >>4 result never exceeds the input range.
   function automatic logic [DEF_DATA_WIDTH-1:0] gauss5_norm(
      input logic [DEF_DATA_WIDTH-1:0] p0,
      input logic [DEF_DATA_WIDTH-1:0] p1,
      input logic [DEF_DATA_WIDTH-1:0] p2,
      input logic [DEF_DATA_WIDTH-1:0] p3,
      input logic [DEF_DATA_WIDTH-1:0] p4
   );
      logic [DEF_DATA_WIDTH+3:0] acc;
      acc = DEF_DATA_WIDTH'(KERNEL_K0) * 0 + {4'd0, p0}
          + ({4'd0, p1} << 2)
          + ({4'd0, p2} << 2) + ({4'd0, p2} << 1)
          + ({4'd0, p3} << 2)
          + {4'd0, p4};
      return acc[KERNEL_SHIFT +: DEF_DATA_WIDTH];
   endfunction

endpackage

// File: rtl/row_delay_line_5x5_segment.sv
// row_delay_segment: DEPTH-stage register delay, shifting only when clken is
// high, cleared asynchronously by aclr_n.
//   clock   in   rising-edge clock
//   aclr_n  in   asynchronous active-low clear of every stage
//   clken   in   shift enable
//   din     in   sample entering stage 1
//   dout    out  stage DEPTH (combinational read of the last register)
module row_delay_segment
   import row_delay_line_5x5_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = IMG_WIDTH
) (
   input  logic                  clock,
   input  logic                  aclr_n,
   input  logic                  clken,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout
);

   logic [DATA_WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (clken) begin
         stage_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/row_delay_line_5x5.sv
// row_delay_line_5x5: four-row line buffer for the 5x5 Gaussian. The pixel
// stream is delayed by whole rows; shiftin plus the four taps form one
// vertical 5-pixel column.
//   clock     in   rising-edge clock
//   aclr_n    in   asynchronous active-low clear, driven straight from rst_n
//   clken     in   pixel-valid strobe; the line only advances when high
//   shiftin   in   incoming pixel
//   taps0x    out  pixel delayed 1 row  (stage TAP_DISTANCE)
//   taps1x    out  pixel delayed 2 rows (stage 2*TAP_DISTANCE)
//   taps2x    out  pixel delayed 3 rows (stage 3*TAP_DISTANCE)
//   taps3x    out  pixel delayed 4 rows (stage 4*TAP_DISTANCE)
//   shiftout  out  end of chain, same as taps3x
// The tap ports are fixed at four, so NUM_TAPS is expected to stay at 4.
module row_delay_line_5x5
   import row_delay_line_5x5_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int TAP_DISTANCE = IMG_WIDTH,
   parameter int NUM_TAPS     = 4
) (
   input  logic                  clock,
   input  logic                  aclr_n,
   input  logic                  clken,
   input  logic [DATA_WIDTH-1:0] shiftin,
   output logic [DATA_WIDTH-1:0] shiftout,
   output logic [DATA_WIDTH-1:0] taps0x,
   output logic [DATA_WIDTH-1:0] taps1x,
   output logic [DATA_WIDTH-1:0] taps2x,
   output logic [DATA_WIDTH-1:0] taps3x
);

   // tap_bus[0] is the live input; tap_bus[k] is the output of segment k.
   logic [DATA_WIDTH-1:0] tap_bus [NUM_TAPS+1];

   assign tap_bus[0] = shiftin;

   for (genvar k = 0; k < NUM_TAPS; k++) begin : g_seg
      row_delay_segment #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (TAP_DISTANCE)
      ) u_seg (
         .clock  (clock),
         .aclr_n (aclr_n),
         .clken  (clken),
         .din    (tap_bus[k]),
         .dout   (tap_bus[k+1])
      );
   end

   assign taps0x   = tap_bus[1];
   assign taps1x   = tap_bus[2];
   assign taps2x   = tap_bus[3];
   assign taps3x   = tap_bus[4];
   assign shiftout = tap_bus[NUM_TAPS];

endmodule

// File: tb/tb_row_delay_line_5x5.sv
module tb_row_delay_line_5x5;

   logic       clock = 1'b0;
   logic       aclr_n = 1'b0;
   logic       clken = 1'b0;
   logic [7:0] shiftin = 8'd0;

   logic [7:0] so9, t0_9, t1_9, t2_9, t3_9;
   logic [7:0] so4, t0_4, t1_4, t2_4, t3_4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   row_delay_line_5x5 #(.DATA_WIDTH(8), .TAP_DISTANCE(9), .NUM_TAPS(4)) dut9 (
      .clock(clock), .aclr_n(aclr_n), .clken(clken), .shiftin(shiftin),
      .shiftout(so9), .taps0x(t0_9), .taps1x(t1_9), .taps2x(t2_9), .taps3x(t3_9)
   );

   row_delay_line_5x5 #(.DATA_WIDTH(8), .TAP_DISTANCE(4), .NUM_TAPS(4)) dut4 (
      .clock(clock), .aclr_n(aclr_n), .clken(clken), .shiftin(shiftin),
      .shiftout(so4), .taps0x(t0_4), .taps1x(t1_4), .taps2x(t2_4), .taps3x(t3_4)
   );

   // Model: list of accepted pixels since reset, newest first. Tap k of a line
   // with row length td is the pixel accepted (k+1)*td pixels ago, or 0.
   logic [7:0] hist [$];

   always @(negedge aclr_n) hist.delete();

   always @(posedge clock) begin
      if (aclr_n && clken) begin
         hist.push_front(shiftin);
         if (hist.size() > 64) void'(hist.pop_back());
      end
   end

   function automatic logic [7:0] model_tap(input int k, input int td);
      int d;
      d = (k + 1) * td;
      if (hist.size() >= d) return hist[d-1];
      return 8'd0;
   endfunction

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      check("m9_t0", t0_9, model_tap(0, 9));
      check("m9_t1", t1_9, model_tap(1, 9));
      check("m9_t2", t2_9, model_tap(2, 9));
      check("m9_t3", t3_9, model_tap(3, 9));
      check("m9_so", so9,  model_tap(3, 9));
      check("m4_t0", t0_4, model_tap(0, 4));
      check("m4_t1", t1_4, model_tap(1, 4));
      check("m4_t2", t2_4, model_tap(2, 4));
      check("m4_t3", t3_4, model_tap(3, 4));
      check("m4_so", so4,  model_tap(3, 4));
   end

   task automatic step(input logic en, input logic [7:0] val);
      clken   = en;
      shiftin = val;
      @(posedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_t0"}, t0_9, 8'd0);
      check({tag, "_t1"}, t1_9, 8'd0);
      check({tag, "_t2"}, t2_9, 8'd0);
      check({tag, "_t3"}, t3_9, 8'd0);
      check({tag, "_so"}, so9,  8'd0);
      check({tag, "_t0_4"}, t0_4, 8'd0);
      check({tag, "_so_4"}, so4,  8'd0);
   endtask

   // Currently at posedge+1 with aclr_n high: pulse clear between edges.
   task automatic pulse_reset(input string tag);
      #2;
      aclr_n = 1'b0;
      #1;
      check_all_zero(tag);
      @(posedge clock);
      #1;
      check_all_zero({tag, "_hold"});
      aclr_n = 1'b1;
   endtask

   // Continuous ramp 1..40 with literal pins on first arrival and steady state.
   task automatic run_ramp(input string tag);
      for (int n = 1; n <= 40; n++) begin
         step(1'b1, 8'(n));
         if (n == 4)  check({tag, "_td4_t0_at4"},  t0_4, 8'd1);
         if (n == 8)  check({tag, "_t0_at8"},      t0_9, 8'd0);
         if (n == 9)  check({tag, "_t0_at9"},      t0_9, 8'd1);
         if (n == 15) check({tag, "_td4_t3_at15"}, t3_4, 8'd0);
         if (n == 16) check({tag, "_td4_t3_at16"}, t3_4, 8'd1);
         if (n == 17) check({tag, "_t1_at17"},     t1_9, 8'd0);
         if (n == 18) check({tag, "_t1_at18"},     t1_9, 8'd1);
         if (n == 27) check({tag, "_t2_at27"},     t2_9, 8'd1);
         if (n == 35) check({tag, "_t3_at35"},     t3_9, 8'd0);
         if (n == 36) begin
            check({tag, "_t3_at36"}, t3_9, 8'd1);
            check({tag, "_so_at36"}, so9,  8'd1);
         end
      end
      check({tag, "_ss_t0"}, t0_9, 8'd32);
      check({tag, "_ss_t1"}, t1_9, 8'd23);
      check({tag, "_ss_t2"}, t2_9, 8'd14);
      check({tag, "_ss_t3"}, t3_9, 8'd5);
      check({tag, "_ss_so"}, so9,  8'd5);
   endtask

   initial begin
      // Reset held with clock running and clken high: nothing may load.
      clken = 1'b1;
      shiftin = 8'hA5;
      repeat (3) @(posedge clock);
      #1;
      check_all_zero("rst");
      aclr_n = 1'b1;

      run_ramp("ramp1");

      // Mid-stream clear, then the ramp must reproduce exactly.
      step(1'b1, 8'd41);
      pulse_reset("mid_rst");
      run_ramp("ramp2");

      // Enable toggling: ramp advances only on accepted pixels.
      pulse_reset("rst_tog");
      begin
         int v;
         logic [7:0] held;
         v = 0;
         held = 8'd0;
         for (int c = 1; c <= 40; c++) begin
            if (c[0]) begin
               v++;
               step(1'b1, 8'(v));
            end else begin
               held = t0_9;
               step(1'b0, 8'hEE);
               check("tog_frozen_t0", t0_9, held);
            end
            if (c == 16) check("tog_t0_at16", t0_9, 8'd0);
            if (c == 17) check("tog_t0_at17", t0_9, 8'd1);
         end
      end

      // Alternating extremes: edge i carries FF when i is odd.
      pulse_reset("rst_alt");
      for (int i = 1; i <= 40; i++) step(1'b1, i[0] ? 8'hFF : 8'h00);
      check("alt_t0", t0_9, 8'h00);
      check("alt_t1", t1_9, 8'hFF);
      check("alt_t2", t2_9, 8'h00);
      check("alt_t3", t3_9, 8'hFF);
      check("alt_so", so9,  8'hFF);
      step(1'b1, 8'h00);
      check("alt_t0_next", t0_9, 8'hFF);
      check("alt_t3_next", t3_9, 8'h00);

      clken = 1'b0;
      @(negedge clock);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
